// File: rtl/simt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simt_pkg
// Purpose  : Shared definitions for the SIMT reconvergence controller:
//            default geometry, controller state encoding and the layout
//            of one reconvergence stack entry.
// Ports    : none (package)
// Options  : SIMT_DIV_STATS_EN (consumed by the interface and top only)
// Revision : 1.0 - initial release
// ============================================================================
package simt_pkg;

  localparam int DEF_LANES    = 8;
  localparam int DEF_PC_WIDTH = 32;
  localparam int DEF_DEPTH    = 8;

  typedef enum logic [0:0] {
    RUN = 1'b0,
    POP = 1'b1
  } state_e;

  // One reconvergence record. phase==0 means the pending (not-taken) path
  // has not run yet; phase==1 means it is running and the next arrival at
  // rpc unwinds this entry. Mask/PC fields are sized by the package
  // defaults, so the controller's LANES/PC_WIDTH must match them.
  typedef struct packed {
    logic [DEF_PC_WIDTH-1:0] rpc;
    logic [DEF_PC_WIDTH-1:0] pend_pc;
    logic [DEF_LANES-1:0]    pend_mask;
    logic [DEF_LANES-1:0]    outer_mask;
    logic                    phase;
  } stack_entry_t;

endpackage
`default_nettype wire

// File: rtl/simt_reconv_ctl_if.sv
`default_nettype none
// ============================================================================
// Module   : simt_reconv_ctl_if
// Purpose  : Branch-stage / fetch side bundle of the reconvergence
//            controller. master = branch stage + fetch, slave = controller.
// Ports    : br_valid/br_ready handshake with br_take, br_target,
//            br_fallthru, br_reconv; pc_adv/pc_next sequential advance;
//            cur_pc, active_mask, redirect, stack_depth back to fetch.
// Options  : SIMT_DIV_STATS_EN adds div_count and depth_hwm.
// Revision : 1.0 - initial release
// ============================================================================
interface simt_reconv_ctl_if #(
  parameter int LANES    = 8,
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 8
);
  localparam int DW = $clog2(DEPTH) + 1;

  logic                br_valid;
  logic                br_ready;
  logic [LANES-1:0]    br_take;
  logic [PC_WIDTH-1:0] br_target;
  logic [PC_WIDTH-1:0] br_fallthru;
  logic [PC_WIDTH-1:0] br_reconv;
  logic                pc_adv;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] cur_pc;
  logic [LANES-1:0]    active_mask;
  logic                redirect;
  logic [DW-1:0]       stack_depth;
`ifdef SIMT_DIV_STATS_EN
  logic [31:0]         div_count;
  logic [DW-1:0]       depth_hwm;
`endif

  modport master (
    output br_valid, br_take, br_target, br_fallthru, br_reconv,
    output pc_adv, pc_next,
    input  br_ready, cur_pc, active_mask, redirect, stack_depth
`ifdef SIMT_DIV_STATS_EN
    , input div_count, depth_hwm
`endif
  );

  modport slave (
    input  br_valid, br_take, br_target, br_fallthru, br_reconv,
    input  pc_adv, pc_next,
    output br_ready, cur_pc, active_mask, redirect, stack_depth
`ifdef SIMT_DIV_STATS_EN
    , output div_count, depth_hwm
`endif
  );

endinterface
`default_nettype wire

// File: rtl/simt_stack_mem.sv
`default_nettype none
// ============================================================================
// Module   : simt_stack_mem
// Purpose  : LIFO of reconvergence entries with a combinational top-of-stack
//            read and an in-place write of the TOS phase bit.
// Ports    : clk, rst_n (sync, active low); push/push_data, pop, set_phase;
//            tos (valid when depth != 0), depth (valid entry count).
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
module simt_stack_mem
  import simt_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,  // power of two, >= 2
  localparam int DW   = $clog2(DEPTH) + 1
) (
  input  wire  logic          clk,
  input  wire  logic          rst_n,
  input  wire  logic          push,
  input  wire  stack_entry_t  push_data,
  input  wire  logic          pop,
  input  wire  logic          set_phase,
  output stack_entry_t        tos,
  output logic [DW-1:0]       depth
);
  localparam int AW = $clog2(DEPTH);

  stack_entry_t  mem [DEPTH];
  logic [DW-1:0] sp;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] tos_idx;

  // Low AW bits wrap naturally: a full stack (sp==DEPTH) gives TOS DEPTH-1.
  assign wr_idx  = sp[AW-1:0];
  assign tos_idx = sp[AW-1:0] - 1'b1;

  // The caller never asserts more than one of push/pop/set_phase, and never
  // pushes when full or pops when empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (push) begin
      sp <= sp + 1'b1;
    end else if (pop) begin
      sp <= sp - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx] <= push_data;
    end else if (set_phase) begin
      mem[tos_idx].phase <= 1'b1;
    end
  end

  assign tos   = mem[tos_idx];
  assign depth = sp;

endmodule
`default_nettype wire

// File: rtl/simt_reconv_ctl.sv
`default_nettype none
// ============================================================================
// Module   : simt_reconv_ctl
// Purpose  : Per-warp SIMT divergence / reconvergence controller. Holds the
//            warp PC and active mask, splits the warp on divergent branches
//            (taken path first), switches to the pending path at the
//            reconvergence PC and finally restores the outer mask.
// Ports    : clk, rst_n (sync, active low); bus (simt_reconv_ctl_if.slave):
//            branch handshake in, pc_adv/pc_next in, cur_pc/active_mask/
//            redirect/stack_depth out.
// Options  : SIMT_DIV_STATS_EN adds div_count (saturating count of accepted
//            divergent branches) and depth_hwm (max stack_depth since reset).
// Revision : 1.0 - initial release
// ============================================================================
module simt_reconv_ctl
  import simt_pkg::*;
#(
  parameter int                  LANES    = DEF_LANES,
  parameter int                  PC_WIDTH = DEF_PC_WIDTH,
  parameter int                  DEPTH    = DEF_DEPTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input wire logic          clk,
  input wire logic          rst_n,
  simt_reconv_ctl_if.slave  bus
);
  localparam int DW = $clog2(DEPTH) + 1;

  // Registered outputs and FSM state
  logic [PC_WIDTH-1:0] cur_pc;
  logic [LANES-1:0]    active_mask;
  logic                redirect;
  state_e              state;

  // Stack interface
  stack_entry_t  tos;
  stack_entry_t  push_data;
  logic [DW-1:0] depth;
  logic          push, pop, set_phase;

  // Next-state terms
  logic [LANES-1:0]    take_m, nt_m;
  logic                br_ready, accept, divergent;
  logic                seq_valid, seq_redirect;
  logic [PC_WIDTH-1:0] seq_pc;
  logic                check_en, match;
  logic [PC_WIDTH-1:0] check_pc;
  logic [PC_WIDTH-1:0] nxt_pc;
  logic [LANES-1:0]    nxt_mask;
  logic                nxt_redirect;
  state_e              nxt_state;

  assign br_ready = (depth != DW'(DEPTH)) && (state == RUN);

  always_comb begin
    take_m    = bus.br_take & active_mask;
    nt_m      = ~bus.br_take & active_mask;
    accept    = bus.br_valid && br_ready;
    divergent = accept && (take_m != '0) && (nt_m != '0);

    // Candidate next PC from a uniform branch or a sequential advance.
    // A presented branch (even one not accepted) blocks pc_adv.
    seq_valid    = 1'b0;
    seq_pc       = cur_pc;
    seq_redirect = 1'b0;
    if (state == RUN) begin
      if (accept && !divergent) begin
        // Non-divergent: any live taken lane means every live lane took.
        // An empty mask therefore falls through.
        seq_valid    = 1'b1;
        seq_redirect = (take_m != '0);
        seq_pc       = (take_m != '0) ? bus.br_target : bus.br_fallthru;
      end else if (!bus.br_valid && bus.pc_adv) begin
        seq_valid = 1'b1;
        seq_pc    = bus.pc_next;
      end
    end

    // In POP the freshly exposed TOS is compared against the PC we just
    // reconverged to, so stacked entries sharing an rpc unwind one a cycle.
    check_pc = (state == POP) ? cur_pc : seq_pc;
    check_en = (state == POP) || seq_valid;
    match    = check_en && (depth != '0) && (tos.rpc == check_pc);

    push      = divergent;
    pop       = match && tos.phase;
    set_phase = match && !tos.phase;

    push_data.rpc        = bus.br_reconv;
    push_data.pend_pc    = bus.br_fallthru;
    push_data.pend_mask  = nt_m;
    push_data.outer_mask = active_mask;
    push_data.phase      = 1'b0;

    nxt_pc       = cur_pc;
    nxt_mask     = active_mask;
    nxt_redirect = 1'b0;
    nxt_state    = RUN;
    if (divergent) begin
      nxt_pc       = bus.br_target;
      nxt_mask     = take_m;
      nxt_redirect = 1'b1;
    end else if (match) begin
      if (tos.phase) begin
        // Both paths done: restore the outer mask at the rpc itself.
        nxt_pc    = tos.rpc;
        nxt_mask  = tos.outer_mask;
        nxt_state = POP;
      end else begin
        nxt_pc       = tos.pend_pc;
        nxt_mask     = tos.pend_mask;
        nxt_redirect = 1'b1;
      end
    end else if (seq_valid) begin
      nxt_pc       = seq_pc;
      nxt_redirect = seq_redirect;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_pc      <= RESET_PC;
      active_mask <= '1;
      redirect    <= 1'b0;
      state       <= RUN;
    end else begin
      cur_pc      <= nxt_pc;
      active_mask <= nxt_mask;
      redirect    <= nxt_redirect;
      state       <= nxt_state;
    end
  end

  simt_stack_mem #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .set_phase (set_phase),
    .tos       (tos),
    .depth     (depth)
  );

  assign bus.br_ready    = br_ready;
  assign bus.cur_pc      = cur_pc;
  assign bus.active_mask = active_mask;
  assign bus.redirect    = redirect;
  assign bus.stack_depth = depth;

`ifdef SIMT_DIV_STATS_EN
  logic [31:0]   div_count;
  logic [DW-1:0] depth_hwm;
  logic [DW-1:0] depth_inc;

  assign depth_inc = depth + 1'b1;

  // A push is the only way depth grows, so the high-water mark only needs
  // updating on a push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_count <= '0;
      depth_hwm <= '0;
    end else if (push) begin
      if (div_count != '1) begin
        div_count <= div_count + 1'b1;
      end
      if (depth_inc > depth_hwm) begin
        depth_hwm <= depth_inc;
      end
    end
  end

  assign bus.div_count = div_count;
  assign bus.depth_hwm = depth_hwm;
`endif

endmodule
`default_nettype wire

// File: tb/tb_simt_reconv_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_simt_reconv_ctl
// Purpose  : Self-checking bench for simt_reconv_ctl. Each scenario task
//            drives one stimulus per cycle, queues the expected outputs and
//            compares them one cycle later. DEPTH is 4 here because with 8
//            lanes at most 7 nested divergences exist, so a full stack needs
//            DEPTH < LANES.
// Options  : SIMT_DIV_STATS_EN enables the statistics checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simt_reconv_ctl;
  localparam int LANES = 8;
  localparam int PCW   = 32;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [PCW-1:0]   pc;
    logic [LANES-1:0] mask;
    logic             rd;
    int               depth;
    logic             ready;
  } exp_t;

  typedef struct {
    logic             br;
    logic [LANES-1:0] take;
    logic [PCW-1:0]   tgt;
    logic [PCW-1:0]   ft;
    logic [PCW-1:0]   rc;
    logic             adv;
    logic [PCW-1:0]   nxt;
    exp_t             e;
  } step_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  simt_reconv_ctl_if #(.LANES(LANES), .PC_WIDTH(PCW), .DEPTH(DEPTH)) bus ();

  simt_reconv_ctl #(
    .LANES    (LANES),
    .PC_WIDTH (PCW),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic step_t mk(input logic br, input logic [7:0] take,
                               input logic [31:0] tgt, input logic [31:0] ft,
                               input logic [31:0] rc, input logic adv,
                               input logic [31:0] nxt, input logic [31:0] e_pc,
                               input logic [7:0] e_mask, input logic e_rd,
                               input int e_depth, input logic e_ready);
    step_t s;
    s.br = br; s.take = take; s.tgt = tgt; s.ft = ft; s.rc = rc;
    s.adv = adv; s.nxt = nxt;
    s.e.pc = e_pc; s.e.mask = e_mask; s.e.rd = e_rd;
    s.e.depth = e_depth; s.e.ready = e_ready;
    return s;
  endfunction

  // Drives one cycle of stimulus and records what the DUT must show after it.
  task automatic drive(input step_t s);
    bus.br_valid    = s.br;
    bus.br_take     = s.take;
    bus.br_target   = s.tgt;
    bus.br_fallthru = s.ft;
    bus.br_reconv   = s.rc;
    bus.pc_adv      = s.adv;
    bus.pc_next     = s.nxt;
    sb.push_back(s.e);
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    drive(mk(0, 8'h00, 0, 0, 0, 0, 0, 32'h0, 8'hFF, 0, 0, 1));
    @(posedge clk); @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (bus.cur_pc !== e.pc || bus.active_mask !== e.mask || bus.redirect !== e.rd ||
        bus.stack_depth !== DW'(e.depth) || bus.br_ready !== e.ready) begin
      errors++;
      $display("FAIL reset: got pc=%h mask=%h rd=%b depth=%0d ready=%b want pc=%h mask=%h rd=%b depth=%0d ready=%b",
               bus.cur_pc, bus.active_mask, bus.redirect, bus.stack_depth, bus.br_ready,
               e.pc, e.mask, e.rd, e.depth, e.ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic run_case(input string name, input step_t steps[]);
    exp_t e;
    foreach (steps[i]) begin
      drive(steps[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (bus.cur_pc !== e.pc || bus.active_mask !== e.mask || bus.redirect !== e.rd ||
          bus.stack_depth !== DW'(e.depth) || bus.br_ready !== e.ready) begin
        errors++;
        $display("FAIL %s[%0d]: got pc=%h mask=%h rd=%b depth=%0d ready=%b want pc=%h mask=%h rd=%b depth=%0d ready=%b",
                 name, i, bus.cur_pc, bus.active_mask, bus.redirect, bus.stack_depth,
                 bus.br_ready, e.pc, e.mask, e.rd, e.depth, e.ready);
      end
    end
  endtask

  task automatic test_sequential();
    step_t s[] = '{
      mk(0, 8'h00, 0, 0, 0, 1, 32'h1, 32'h1, 8'hFF, 0, 0, 1),
      mk(0, 8'h00, 0, 0, 0, 1, 32'h2, 32'h2, 8'hFF, 0, 0, 1),
      mk(0, 8'h00, 0, 0, 0, 0, 32'h9, 32'h2, 8'hFF, 0, 0, 1)
    };
    run_case("seq", s);
  endtask

  task automatic test_uniform();
    step_t s[] = '{
      mk(1, 8'hFF, 32'h40, 32'h3,  32'h99, 0, 0, 32'h40, 8'hFF, 1, 0, 1),
      mk(0, 8'h00, 0, 0, 0, 0, 0,                   32'h40, 8'hFF, 0, 0, 1),
      mk(1, 8'h00, 32'h70, 32'h41, 32'h99, 0, 0, 32'h41, 8'hFF, 0, 0, 1)
    };
    run_case("uniform", s);
  endtask

  task automatic test_diverge();
    step_t s[] = '{
      mk(1, 8'h0F, 32'h30, 32'h11, 32'h20, 0, 0,     32'h30, 8'h0F, 1, 1, 1),
      mk(0, 8'h00, 0, 0, 0,                1, 32'h31, 32'h31, 8'h0F, 0, 1, 1),
      // raw bits mixed, but only lanes 7:4 take and they are inactive
      mk(1, 8'hF0, 32'h90, 32'h32, 32'h77, 0, 0,     32'h32, 8'h0F, 0, 1, 1),
      // uniform taken branch landing on the rpc switches to pending path
      mk(1, 8'hFF, 32'h20, 32'h33, 32'h77, 0, 0,     32'h11, 8'hF0, 1, 1, 1),
      mk(0, 8'h00, 0, 0, 0,                1, 32'h20, 32'h20, 8'hFF, 0, 0, 0),
      mk(0, 8'h00, 0, 0, 0,                0, 0,      32'h20, 8'hFF, 0, 0, 1)
    };
    run_case("diverge", s);
  endtask

  task automatic test_nested_pop();
    step_t s[] = '{
      mk(1, 8'h0F, 32'h30, 32'h11, 32'h60, 0, 0,     32'h30, 8'h0F, 1, 1, 1),
      mk(0, 8'h00, 0, 0, 0,                1, 32'h60, 32'h11, 8'hF0, 1, 1, 1),
      mk(1, 8'h30, 32'h50, 32'h12, 32'h60, 0, 0,     32'h50, 8'h30, 1, 2, 1),
      mk(0, 8'h00, 0, 0, 0,                1, 32'h60, 32'h12, 8'hC0, 1, 2, 1),
      mk(0, 8'h00, 0, 0, 0,                1, 32'h60, 32'h60, 8'hF0, 0, 1, 0),
      // POP cycles: branch and pc_adv offered but must be ignored
      mk(1, 8'h0F, 32'hA0, 32'h61, 32'hB0, 1, 32'h99, 32'h60, 8'hFF, 0, 0, 0),
      mk(1, 8'h0F, 32'hA0, 32'h61, 32'hB0, 1, 32'h99, 32'h60, 8'hFF, 0, 0, 1)
    };
    run_case("nested", s);
  endtask

  task automatic test_full_and_reset();
    exp_t e;
    step_t s[] = '{
      mk(1, 8'h7F, 32'h100, 32'h61,  32'h200, 0, 0, 32'h100, 8'h7F, 1, 1, 1),
      mk(1, 8'h3F, 32'h110, 32'h101, 32'h1F0, 0, 0, 32'h110, 8'h3F, 1, 2, 1),
      mk(1, 8'h1F, 32'h120, 32'h111, 32'h1E0, 0, 0, 32'h120, 8'h1F, 1, 3, 1),
      mk(1, 8'h0F, 32'h130, 32'h121, 32'h1D0, 0, 0, 32'h130, 8'h0F, 1, 4, 0),
      mk(1, 8'h07, 32'h140, 32'h131, 32'h1C0, 1, 32'h999, 32'h130, 8'h0F, 0, 4, 0),
      mk(1, 8'h07, 32'h140, 32'h131, 32'h1C0, 1, 32'h999, 32'h130, 8'h0F, 0, 4, 0)
    };
    run_case("full", s);
`ifdef SIMT_DIV_STATS_EN
    checks++;
    if (bus.div_count !== 32'd7 || bus.depth_hwm !== DW'(4)) begin
      errors++;
      $display("FAIL stats: got div_count=%0d hwm=%0d want div_count=7 hwm=4",
               bus.div_count, bus.depth_hwm);
    end
`endif
    rst_n = 1'b0;
    drive(mk(0, 8'h00, 0, 0, 0, 0, 0, 32'h0, 8'hFF, 0, 0, 1));
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (bus.cur_pc !== e.pc || bus.active_mask !== e.mask || bus.redirect !== e.rd ||
        bus.stack_depth !== DW'(e.depth) || bus.br_ready !== e.ready) begin
      errors++;
      $display("FAIL mid_reset: got pc=%h mask=%h rd=%b depth=%0d ready=%b want pc=%h mask=%h rd=%b depth=%0d ready=%b",
               bus.cur_pc, bus.active_mask, bus.redirect, bus.stack_depth, bus.br_ready,
               e.pc, e.mask, e.rd, e.depth, e.ready);
    end
`ifdef SIMT_DIV_STATS_EN
    checks++;
    if (bus.div_count !== 32'd0 || bus.depth_hwm !== DW'(0)) begin
      errors++;
      $display("FAIL stats_reset: got div_count=%0d hwm=%0d want 0 0",
               bus.div_count, bus.depth_hwm);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_branch_wins();
    step_t s[] = '{
      mk(1, 8'hFF, 32'h80, 32'h1,  32'h5, 1, 32'h7,  32'h80, 8'hFF, 1, 0, 1),
      mk(1, 8'h0F, 32'h90, 32'h81, 32'h7, 1, 32'h7,  32'h90, 8'h0F, 1, 1, 1),
      // divergent branch targeting the TOS rpc: no reconvergence this cycle
      mk(1, 8'h03, 32'h7,  32'h91, 32'h7, 0, 0,      32'h7,  8'h03, 1, 2, 1),
      mk(0, 8'h00, 0, 0, 0,               1, 32'h95, 32'h95, 8'h03, 0, 2, 1)
    };
    run_case("br_wins", s);
  endtask

  initial begin
    bus.br_valid = 1'b0; bus.br_take = '0; bus.br_target = '0;
    bus.br_fallthru = '0; bus.br_reconv = '0; bus.pc_adv = 1'b0; bus.pc_next = '0;
    test_reset();
    test_sequential();
    test_uniform();
    test_diverge();
    test_nested_pop();
    test_full_and_reset();
    test_branch_wins();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
